code_lock: RTL and testbench

CODE_LOCK -- requirements
Module: code_lock

---
 rtl/code_lock_pkg.sv | 27 ++
 rtl/code_lock_btn_edge.sv | 34 +++
 rtl/code_lock.sv | 186 ++++++++++++++++++
 tb/tb_code_lock.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// code_lock_pkg : shared state encoding and width helpers for the code lock
// Revision 1.0
// ---------------------------------------------------------------------------
package code_lock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ENTRY   = 3'd1,
      ST_OK      = 3'd2,
      ST_FAIL    = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_t;

   function automatic int clog2_min1(input int value);
      int r;
      r = $clog2(value);
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/code_lock_btn_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_edge : two-flop synchroniser with a one-cycle release-edge pulse
// Revision 1.0
// ---------------------------------------------------------------------------
module btn_edge (
   input  logic clk,
   input  logic n_rst,
   input  logic btn,
   output logic release_pulse
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;

   always_comb begin
      s1_d = btn;
      s2_d = s1_q;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign release_pulse = s2_q & ~s1_q;

endmodule
`default_nettype wire

// File: rtl/code_lock.sv
`default_nettype none
// ---------------------------------------------------------------------------
// code_lock : keypad code lock with entry timeout and failure lockout
// Revision 1.0
// ---------------------------------------------------------------------------
module code_lock
   import code_lock_pkg::*;
#(
   parameter int NUM_BTN  = 4,
   parameter int CODE_LEN = 4,
   parameter int MAX_FAIL = 3,
   parameter int TIMEOUT  = 1000,
   parameter int LOCKOUT  = 5000
) (
   input  logic                                   clk,
   input  logic                                   n_rst,
   input  logic                                   start,
   input  logic [NUM_BTN-1:0]                     button,
   input  logic [CODE_LEN*clog2_min1(NUM_BTN)-1:0] code,
   output logic                                   led_ok,
   output logic                                   led_fail,
   output logic                                   led_lock,
   output logic [NUM_BTN-1:0]                     led_btn,
   output logic [3:0]                             fail_cnt
);

   localparam int BTN_W = clog2_min1(NUM_BTN);
   localparam int IDX_W = clog2_min1(CODE_LEN);
   localparam int CNT_W = clog2_min1(max_int(TIMEOUT, LOCKOUT) + 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(CODE_LEN - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LOCKOUT_LAST = CNT_W'(LOCKOUT - 1);
   localparam logic [3:0]       FAIL_LIMIT   = 4'(MAX_FAIL);

   logic [NUM_BTN-1:0] ev;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_edge u_btn_edge (
         .clk           (clk),
         .n_rst         (n_rst),
         .btn           (button[gi]),
         .release_pulse (ev[gi])
      );
   end

   state_t                    state_q, state_d;
   logic [CODE_LEN*BTN_W-1:0] code_q, code_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      mism_q, mism_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [3:0]                fail_cnt_q, fail_cnt_d;
   logic                      led_ok_q, led_ok_d;
   logic                      led_fail_q, led_fail_d;
   logic                      led_lock_q, led_lock_d;
   logic [NUM_BTN-1:0]        led_btn_q, led_btn_d;

   logic             any_ev;
   logic             multi_ev;
   logic [BTN_W-1:0] btn_idx;
   logic [BTN_W-1:0] digit;
   logic             mism_new;
   logic [3:0]       fail_inc;
   logic             to_fail;

   always_comb begin
      any_ev   = |ev;
      multi_ev = |(ev & (ev - NUM_BTN'(1)));
      btn_idx  = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (ev[i]) btn_idx = BTN_W'(i);
      end
      digit = '0;
      for (int i = 0; i < CODE_LEN; i++) begin
         if (idx_q == IDX_W'(i)) digit = code_q[i*BTN_W +: BTN_W];
      end
      // Simultaneous releases still consume a digit but can never match.
      mism_new = mism_q | multi_ev | (btn_idx != digit);
      fail_inc = (fail_cnt_q == 4'hF) ? 4'hF : fail_cnt_q + 4'd1;
   end

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      idx_d      = idx_q;
      mism_d     = mism_q;
      cnt_d      = cnt_q;
      fail_cnt_d = fail_cnt_q;
      to_fail    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ENTRY;
               code_d  = code;
               idx_d   = '0;
               mism_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         ST_ENTRY: begin
            if (!start) begin
               state_d = ST_IDLE;
            end else if (any_ev) begin
               cnt_d = '0;
               if (idx_q == LAST_IDX) begin
                  if (mism_new) begin
                     to_fail = 1'b1;
                  end else begin
                     state_d    = ST_OK;
                     fail_cnt_d = 4'd0;
                  end
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  mism_d = mism_new;
               end
            end else if (cnt_q == TIMEOUT_LAST) begin
               to_fail = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_OK, ST_FAIL: begin
            if (!start) state_d = ST_IDLE;
         end
         ST_LOCKOUT: begin
            if (cnt_q == LOCKOUT_LAST) begin
               state_d    = ST_IDLE;
               fail_cnt_d = 4'd0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (to_fail) begin
         fail_cnt_d = fail_inc;
         cnt_d      = '0;
         state_d    = (fail_inc == FAIL_LIMIT) ? ST_LOCKOUT : ST_FAIL;
      end
   end

   always_comb begin
      led_ok_d   = (state_d == ST_OK);
      led_fail_d = (state_d == ST_FAIL);
      led_lock_d = (state_d == ST_LOCKOUT);
      led_btn_d  = '0;
      if (state_d == ST_ENTRY) begin
         led_btn_d = (state_q == ST_ENTRY && any_ev && !multi_ev) ? ev : led_btn_q;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= ST_IDLE;
         code_q     <= '0;
         idx_q      <= '0;
         mism_q     <= 1'b0;
         cnt_q      <= '0;
         fail_cnt_q <= 4'd0;
         led_ok_q   <= 1'b0;
         led_fail_q <= 1'b0;
         led_lock_q <= 1'b0;
         led_btn_q  <= '0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         idx_q      <= idx_d;
         mism_q     <= mism_d;
         cnt_q      <= cnt_d;
         fail_cnt_q <= fail_cnt_d;
         led_ok_q   <= led_ok_d;
         led_fail_q <= led_fail_d;
         led_lock_q <= led_lock_d;
         led_btn_q  <= led_btn_d;
      end
   end

   assign led_ok   = led_ok_q;
   assign led_fail = led_fail_q;
   assign led_lock = led_lock_q;
   assign led_btn  = led_btn_q;
   assign fail_cnt = fail_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_code_lock.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_code_lock : directed vectors and corner sequences for code_lock
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_code_lock;

   logic       clk;
   logic       n_rst;
   logic       start;
   logic [3:0] button;
   logic [7:0] code;
   logic       led_ok;
   logic       led_fail;
   logic       led_lock;
   logic [3:0] led_btn;
   logic [3:0] fail_cnt;

   int n_pass;
   int n_total;

   code_lock dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .start    (start),
      .button   (button),
      .code     (code),
      .led_ok   (led_ok),
      .led_fail (led_fail),
      .led_lock (led_lock),
      .led_btn  (led_btn),
      .fail_cnt (fail_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Digit 0 sits in the low nibble; code 2,0,3,1 -> masks 4,1,8,2.
   typedef struct packed {
      logic [15:0] masks;
      logic        exp_ok;
      logic        exp_fail;
      logic [3:0]  exp_cnt;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] m);
      button = m;
      repeat (3) tick();
      button = 4'b0000;
      repeat (2) tick();
   endtask

   task automatic session(input logic [15:0] masks);
      start = 1'b1;
      tick();
      for (int j = 0; j < 4; j++) press(masks[j*4 +: 4]);
   endtask

   initial begin
      logic [3:0] exp_btn;
      logic [3:0] m;
      int         lock_cycles;

      n_pass  = 0;
      n_total = 0;
      n_rst   = 1'b0;
      start   = 1'b0;
      button  = 4'b0000;
      code    = 8'h72;

      vecs[0] = '{16'h2814, 1'b1, 1'b0, 4'd0};
      vecs[1] = '{16'h2824, 1'b0, 1'b1, 4'd1};
      vecs[2] = '{16'h2222, 1'b0, 1'b1, 4'd2};
      vecs[3] = '{16'h2814, 1'b1, 1'b0, 4'd0};
      vecs[4] = '{16'h8888, 1'b0, 1'b1, 4'd1};
      vecs[5] = '{16'h2813, 1'b0, 1'b1, 4'd2};
      vecs[6] = '{16'h2814, 1'b1, 1'b0, 4'd0};

      #12;
      check("rst_leds", 32'({led_ok, led_fail, led_lock}), 32'd0);
      check("rst_btn", 32'(led_btn), 32'd0);
      check("rst_cnt", 32'(fail_cnt), 32'd0);
      tick();
      n_rst = 1'b1;
      tick();

      for (int r = 0; r < 7; r++) begin
         start   = 1'b1;
         tick();
         exp_btn = 4'b0000;
         for (int j = 0; j < 3; j++) begin
            m = vecs[r].masks[j*4 +: 4];
            press(m);
            if ($onehot(m)) exp_btn = m;
            check($sformatf("v%0d_d%0d_btn", r, j), 32'(led_btn), 32'(exp_btn));
            check($sformatf("v%0d_d%0d_early", r, j), 32'({led_ok, led_fail}), 32'd0);
         end
         button = vecs[r].masks[15:12];
         repeat (3) tick();
         button = 4'b0000;
         tick();
         check($sformatf("v%0d_pre", r), 32'({led_ok, led_fail}), 32'd0);
         tick();
         check($sformatf("v%0d_ok", r), 32'(led_ok), 32'(vecs[r].exp_ok));
         check($sformatf("v%0d_fail", r), 32'(led_fail), 32'(vecs[r].exp_fail));
         check($sformatf("v%0d_lock", r), 32'(led_lock), 32'd0);
         check($sformatf("v%0d_cnt", r), 32'(fail_cnt), 32'(vecs[r].exp_cnt));
         check($sformatf("v%0d_btnclr", r), 32'(led_btn), 32'd0);
         start = 1'b0;
         repeat (2) tick();
         check($sformatf("v%0d_idle", r), 32'({led_ok, led_fail, led_lock}), 32'd0);
      end

      // Entry timeout: exactly TIMEOUT idle cycles after the last release.
      start = 1'b1;
      tick();
      press(4'b0100);
      repeat (999) tick();
      check("to_before", 32'(led_fail), 32'd0);
      tick();
      check("to_fail", 32'(led_fail), 32'd1);
      check("to_cnt", 32'(fail_cnt), 32'd1);
      start = 1'b0;
      repeat (2) tick();

      // Abort after two digits leaves fail_cnt alone.
      start = 1'b1;
      tick();
      press(4'b0100);
      press(4'b0001);
      check("ab_btn", 32'(led_btn), 32'h1);
      start = 1'b0;
      repeat (2) tick();
      check("ab_leds", 32'({led_ok, led_fail, led_lock}), 32'd0);
      check("ab_btnclr", 32'(led_btn), 32'd0);
      check("ab_cnt", 32'(fail_cnt), 32'd1);

      // Code changed after the session starts must not matter.
      start = 1'b1;
      tick();
      code = 8'h00;
      for (int j = 0; j < 4; j++) press(vecs[0].masks[j*4 +: 4]);
      check("cc_ok", 32'(led_ok), 32'd1);
      check("cc_cnt", 32'(fail_cnt), 32'd0);
      start = 1'b0;
      code  = 8'h72;
      repeat (2) tick();

      // Three failures -> lockout that ignores start=0.
      session(16'h2222);
      start = 1'b0;
      repeat (2) tick();
      session(16'h2222);
      start = 1'b0;
      repeat (2) tick();
      check("lk_cnt2", 32'(fail_cnt), 32'd2);
      session(16'h2222);
      check("lk_lock", 32'(led_lock), 32'd1);
      check("lk_nofail", 32'(led_fail), 32'd0);
      check("lk_cnt3", 32'(fail_cnt), 32'd3);
      start = 1'b0;
      lock_cycles = 0;
      while (led_lock && lock_cycles < 6000) begin
         lock_cycles++;
         tick();
      end
      check("lk_len", 32'(lock_cycles), 32'd5000);
      check("lk_exit_cnt", 32'(fail_cnt), 32'd0);
      check("lk_exit_leds", 32'({led_ok, led_fail, led_lock}), 32'd0);

      // Asynchronous reset while locked out.
      session(16'h2222);
      start = 1'b0;
      repeat (2) tick();
      session(16'h2222);
      start = 1'b0;
      repeat (2) tick();
      session(16'h2222);
      start = 1'b0;
      check("rl_lock", 32'(led_lock), 32'd1);
      repeat (100) tick();
      #3 n_rst = 1'b0;
      #1;
      check("rl_outs", 32'({led_ok, led_fail, led_lock, led_btn, fail_cnt}), 32'd0);
      #2 n_rst = 1'b1;
      tick();
      session(16'h2814);
      check("rl_ok", 32'(led_ok), 32'd1);
      check("rl_cnt", 32'(fail_cnt), 32'd0);
      start = 1'b0;
      repeat (2) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
